// File: rtl/array_3d_fill_seq.sv
// Fill sequencer for a packed [DI][DJ][DK][DW] array: one element per clock, k fastest,
// element value = base + i + j + k. Optional stall input under `ARRAY_FILL_STALL_EN.
module array_3d_fill_seq #(
  parameter int DI = 4,
  parameter int DJ = 3,
  parameter int DK = 2,
  parameter int DW = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [DW-1:0]                         base,
`ifdef ARRAY_FILL_STALL_EN
  input  logic                                  stall,
`endif
  output logic                                  busy,
  output logic                                  done,
  output logic                                  wr_en,
  output logic [((DI > 1) ? $clog2(DI) : 1)-1:0] wr_i,
  output logic [((DJ > 1) ? $clog2(DJ) : 1)-1:0] wr_j,
  output logic [((DK > 1) ? $clog2(DK) : 1)-1:0] wr_k,
  output logic [DW-1:0]                         wr_dat,
  output logic [DI-1:0][DJ-1:0][DK-1:0][DW-1:0] array_q
);

  localparam int IW = (DI > 1) ? $clog2(DI) : 1;
  localparam int JW = (DJ > 1) ? $clog2(DJ) : 1;
  localparam int KW = (DK > 1) ? $clog2(DK) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [IW-1:0] i_r;
  logic [JW-1:0] j_r;
  logic [KW-1:0] k_r;
  logic [DW-1:0] base_r;
  logic          stall_s;
  logic          adv_s;
  logic          last_s;
  logic [DW-1:0] sum_s;

`ifdef ARRAY_FILL_STALL_EN
  assign stall_s = stall;
`else
  assign stall_s = 1'b0;
`endif

  // Advance qualifier, last-element detect and element value (modulo 2^DW).
  always_comb begin
    last_s = (i_r == IW'(DI - 1)) && (j_r == JW'(DJ - 1)) && (k_r == KW'(DK - 1));
    adv_s  = (state_r == ST_RUN) && !stall_s;
    sum_s  = base_r + DW'(i_r) + DW'(j_r) + DW'(k_r);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; DONE always lasts exactly one cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_RUN;
        else       state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (adv_s && last_s) state_s = ST_DONE;
        else                 state_s = ST_RUN;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Index walk (k fastest) and base capture on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_r    <= '0;
      j_r    <= '0;
      k_r    <= '0;
      base_r <= '0;
    end else if (state_r == ST_IDLE) begin
      if (start) begin
        base_r <= base;
        i_r    <= '0;
        j_r    <= '0;
        k_r    <= '0;
      end
    end else if (adv_s) begin
      if (k_r == KW'(DK - 1)) begin
        k_r <= '0;
        if (j_r == JW'(DJ - 1)) begin
          j_r <= '0;
          if (i_r == IW'(DI - 1)) i_r <= '0;
          else                    i_r <= i_r + IW'(1);
        end else begin
          j_r <= j_r + JW'(1);
        end
      end else begin
        k_r <= k_r + KW'(1);
      end
    end
  end

  // Array storage: only reset clears it, runs overwrite in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      array_q <= '0;
    end else if (adv_s) begin
      array_q[i_r][j_r][k_r] <= sum_s;
    end
  end

  // Observer outputs decoded from registered state.
  always_comb begin
    busy   = (state_r != ST_IDLE);
    done   = (state_r == ST_DONE);
    wr_en  = adv_s;
    wr_i   = i_r;
    wr_j   = j_r;
    wr_k   = k_r;
    if (state_r == ST_RUN) wr_dat = sum_s;
    else                   wr_dat = '0;
  end

endmodule

// File: tb/tb_array_3d_fill_seq.sv
// Bench for array_3d_fill_seq: per-cycle comparison against a write-count based reference
// model, an element table, random traffic and hand-written multi-cycle sequences.
module tb_array_3d_fill_seq;

  localparam int DI = 4;
  localparam int DJ = 3;
  localparam int DK = 2;
  localparam int DW = 8;
  localparam int N  = DI * DJ * DK;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic [7:0] base = 8'h00;
  logic       busy, done, wr_en;
  logic [1:0] wr_i, wr_j;
  logic [0:0] wr_k;
  logic [7:0] wr_dat;
  logic [DI-1:0][DJ-1:0][DK-1:0][DW-1:0] array_q;

  array_3d_fill_seq #(.DI(DI), .DJ(DJ), .DK(DK), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base),
`ifdef ARRAY_FILL_STALL_EN
    .stall(stall),
`endif
    .busy(busy), .done(done), .wr_en(wr_en), .wr_i(wr_i), .wr_j(wr_j), .wr_k(wr_k),
    .wr_dat(wr_dat), .array_q(array_q)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  // Reference model: a run is "write number m_t of N", nothing more.
  bit         m_act;
  bit         m_done;
  int         m_t;
  logic [7:0] m_base;
  logic [DI-1:0][DJ-1:0][DK-1:0][DW-1:0] m_arr;

  typedef struct {
    logic [7:0] base;
    int         i;
    int         j;
    int         k;
    logic [7:0] val;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_act  = 1'b0;
    m_done = 1'b0;
    m_t    = 0;
    m_base = 8'h00;
    m_arr  = '0;
  endtask

  task automatic check_outputs();
    int ii, jj, kk;
    logic [7:0] e_dat;
    ii = m_act ? m_t / (DJ * DK) : 0;
    jj = m_act ? (m_t / DK) % DJ : 0;
    kk = m_act ? m_t % DK : 0;
    e_dat = m_act ? 8'(m_base + 8'(ii + jj + kk)) : 8'h00;
    chk("busy",    256'(busy),    256'(m_act || m_done));
    chk("done",    256'(done),    256'(m_done));
    chk("wr_en",   256'(wr_en),   256'(m_act && !stall));
    chk("wr_i",    256'(wr_i),    256'(ii));
    chk("wr_j",    256'(wr_j),    256'(jj));
    chk("wr_k",    256'(wr_k),    256'(kk));
    chk("wr_dat",  256'(wr_dat),  256'(e_dat));
    chk("array_q", 256'(array_q), 256'(m_arr));
    if (wr_en === 1'b1) wr_cnt++;
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic model_edge(input bit st, input logic [7:0] b);
    if (m_act) begin
      if (!stall) begin
        m_arr[m_t / (DJ * DK)][(m_t / DK) % DJ][m_t % DK] =
          8'(m_base + 8'(m_t / (DJ * DK) + (m_t / DK) % DJ + m_t % DK));
        m_t++;
        if (m_t == N) begin
          m_act  = 1'b0;
          m_done = 1'b1;
          m_t    = 0;
        end
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (st) begin
      m_act  = 1'b1;
      m_t    = 0;
      m_base = b;
    end
  endtask

  // One clock: drive at negedge, compare, let the edge happen, advance the model.
  task automatic cycle(input bit st, input logic [7:0] b);
    start = st;
    base  = b;
    check_outputs();
    @(posedge clk);
    model_edge(st, b);
    @(negedge clk);
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_run(input logic [7:0] b);
    wr_cnt = 0;
    done_cnt = 0;
    cycle(1'b1, b);
    for (int c = 0; c < 100 && done_cnt == 0; c++) cycle(1'b0, 8'h55);
    chk("run_writes", 256'(wr_cnt), 256'(N));
    chk("run_done",   256'(done_cnt), 256'(1));
  endtask

  task automatic drain();
    for (int c = 0; c < 100 && (m_act || m_done); c++) cycle(1'b0, 8'h00);
  endtask

  initial begin
    int first2, dc;
    tbl[0] = '{8'h00, 0, 0, 0, 8'h00};
    tbl[1] = '{8'h00, 2, 1, 0, 8'h03};
    tbl[2] = '{8'h00, 3, 2, 1, 8'h06};
    tbl[3] = '{8'hFE, 0, 0, 0, 8'hFE};
    tbl[4] = '{8'hFE, 0, 0, 1, 8'hFF};
    tbl[5] = '{8'hFE, 3, 2, 1, 8'h04};

    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Element table: a run per distinct base, then spot-check elements.
    for (int r = 0; r < 6; r++) begin
      if (r == 0 || tbl[r].base != tbl[r-1].base) do_run(tbl[r].base);
      chk("elem", 256'(array_q[tbl[r].i][tbl[r].j][tbl[r].k]), 256'(tbl[r].val));
    end

    // Start re-pulsed during write 5 is ignored.
    wr_cnt = 0;
    done_cnt = 0;
    cycle(1'b1, 8'h10);
    for (int c = 0; c < 100 && done_cnt == 0; c++) cycle(m_act && m_t == 4, 8'h40);
    chk("repulse_writes", 256'(wr_cnt), 256'(N));
    chk("repulse_done",   256'(done_cnt), 256'(1));
    chk("repulse_elem",   256'(array_q[3][2][1]), 256'(8'h16));

    // Reset during write 10 aborts immediately; next run restarts at (0,0,0).
    cycle(1'b1, 8'h20);
    for (int c = 0; c < 40 && !(m_act && m_t == 9); c++) cycle(1'b0, 8'h00);
    chk("pre_reset_wr_en", 256'(wr_en), 256'(1));
    reset_now();
    chk("post_reset_array", 256'(array_q), 256'(0));
    do_run(8'h01);
    chk("restart_elem", 256'(array_q[0][0][0]), 256'(8'h01));

    // Start held high: back-to-back runs.
    wr_cnt = 0;
    done_cnt = 0;
    first2 = -1;
    dc = 0;
    for (int c = 0; c < 2 * N + 5; c++) begin
      if (done === 1'b1) dc = 1;
      if (dc == 1 && wr_en === 1'b1 && first2 < 0) first2 = c;
      cycle(1'b1, 8'h30);
    end
    chk("held_restart_cycle", 256'(first2), 256'(N + 3));
    chk("held_done_count",    256'(done_cnt), 256'(2));
    drain();

`ifdef ARRAY_FILL_STALL_EN
    // Three stalled cycles at write 7 push done out by three cycles.
    dc = -1;
    cycle(1'b1, 8'h00);
    for (int c = 1; c < 60 && dc < 0; c++) begin
      stall = (c >= 7 && c <= 9);
      if (done === 1'b1) dc = c;
      cycle(1'b0, 8'h00);
    end
    stall = 1'b0;
    chk("stall_done_cycle", 256'(dc), 256'(N + 4));
    for (int i = 0; i < DI; i++)
      for (int j = 0; j < DJ; j++)
        for (int k = 0; k < DK; k++)
          chk("stall_elem", 256'(array_q[i][j][k]), 256'(8'(i + j + k)));
`endif

    // Random traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) == 0) reset_now();
`ifdef ARRAY_FILL_STALL_EN
      stall = ($urandom_range(0, 3) == 0);
`endif
      cycle($urandom_range(0, 3) == 0, 8'($urandom));
    end
    stall = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
